// File: rtl/legup_mutex_pkg.sv
// legup_mutex_pkg
// Shared definitions for the hardware mutex client and slave:
// register-word addresses on the mutex slave, the "free" owner value and
// the client FSM state encoding.
package legup_mutex_pkg;

  // Word 0 holds the owner ID (write to acquire, read back to confirm),
  // word 1 is written with the owner ID to release.
  localparam logic        MUTEX_ADDR_ACQUIRE = 1'b0;
  localparam logic        MUTEX_ADDR_RELEASE = 1'b1;

  // An owner value of zero means nobody holds the mutex.
  localparam logic [31:0] MUTEX_OWNER_FREE   = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQ_WR,
    ST_ACQ_RD,
    ST_BACKOFF,
    ST_HELD,
    ST_REL_WR
  } mutex_client_state_t;

endpackage

// File: rtl/legup_mutex_client_if.sv
// legup_mutex_client_if
// Avalon-MM bundle between a mutex client (master) and the interconnect /
// mutex slave.
//   avm_address      0 = acquire/owner word, 1 = release word
//   avm_read         read strobe
//   avm_write        write strobe
//   avm_writedata    32-bit write data (owner ID)
//   avm_readdata     32-bit read data (current owner), zero read latency
//   avm_waitrequest  stalls the current read or write
interface legup_mutex_client_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/legup_mutex_backoff.sv
// legup_mutex_backoff
// Exponential backoff timer for the mutex client. Holds the current backoff
// length (1, 2, 4, ... saturating at all-ones) and a down-counter loaded
// from it after each failed acquire.
//   clk, reset_n  clock and asynchronous active-low reset
//   init_i        restart the length at 1 (new lock request)
//   load_i        start a backoff wait of the current length
//   tick_i        high while the client is waiting in backoff
//   expired_o     the wait is over on the current tick
module legup_mutex_backoff #(
  parameter int BACKOFF_W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic init_i,
  input  logic load_i,
  input  logic tick_i,
  output logic expired_o
);

  logic [BACKOFF_W-1:0] length_q;
  logic [BACKOFF_W-1:0] count_q;

  // The counter is loaded with length-1 so that a length of L keeps the
  // client off the bus for exactly L cycles. The length doubles on the tick
  // that ends a wait, and sticks at all-ones once the top bit is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      length_q <= BACKOFF_W'(1);
      count_q  <= '0;
    end else begin
      if (init_i) begin
        length_q <= BACKOFF_W'(1);
      end else if (tick_i && (count_q == '0)) begin
        length_q <= length_q[BACKOFF_W-1] ? '1 : {length_q[BACKOFF_W-2:0], 1'b0};
      end

      if (load_i) begin
        count_q <= length_q - BACKOFF_W'(1);
      end else if (tick_i && (count_q != '0)) begin
        count_q <= count_q - BACKOFF_W'(1);
      end
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/legup_mutex_client.sv
// legup_mutex_client
// Avalon-MM master that acquires and releases one hardware mutex on behalf
// of an accelerator: acquire-write, owner read-back, exponential backoff on
// contention, release-write.
//   clk, reset_n   clock and asynchronous active-low reset
//   lock_req       level request to acquire the mutex
//   unlock_req     level request to release the mutex
//   done           one-cycle pulse when a request completes
//   locked         high while this client owns the mutex
//   retries        failed acquire attempts in the current request (saturating)
//   avm            Avalon-MM master port towards the mutex slave
module legup_mutex_client
  import legup_mutex_pkg::*;
#(
  parameter logic [31:0] ACCEL_ID  = 32'h0000_0001,
  parameter int          BACKOFF_W = 8,
  parameter int          RETRY_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lock_req,
  input  logic               unlock_req,
  output logic               done,
  output logic               locked,
  output logic [RETRY_W-1:0] retries,
  legup_mutex_client_if.master avm
);

  mutex_client_state_t state_q;
  logic                done_q;
  logic                locked_q;
  logic [RETRY_W-1:0]  retries_q;
  logic                avmRead_q;
  logic                avmWrite_q;
  logic                avmAddr_q;
  logic [31:0]         avmWdata_q;

  logic acquireOk;
  logic backoffInit;
  logic backoffLoad;
  logic backoffTick;
  logic backoffExpired;

  assign acquireOk   = (avm.avm_readdata == ACCEL_ID);
  assign backoffInit = (state_q == ST_IDLE) && lock_req;
  assign backoffLoad = (state_q == ST_ACQ_RD) && !avm.avm_waitrequest && !acquireOk;
  assign backoffTick = (state_q == ST_BACKOFF);

  legup_mutex_backoff #(
    .BACKOFF_W (BACKOFF_W)
  ) u_backoff (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_i    (backoffInit),
    .load_i    (backoffLoad),
    .tick_i    (backoffTick),
    .expired_o (backoffExpired)
  );

  // Client FSM. Bus strobes, address and data are registered together with
  // the state so they are only ever changed on an accepted transfer, which
  // keeps them stable across waitrequest stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      retries_q  <= '0;
      avmRead_q  <= 1'b0;
      avmWrite_q <= 1'b0;
      avmAddr_q  <= MUTEX_ADDR_ACQUIRE;
      avmWdata_q <= MUTEX_OWNER_FREE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (lock_req) begin
            state_q    <= ST_ACQ_WR;
            retries_q  <= '0;
            avmWrite_q <= 1'b1;
            avmAddr_q  <= MUTEX_ADDR_ACQUIRE;
            avmWdata_q <= ACCEL_ID;
          end else if (unlock_req) begin
            done_q <= 1'b1;
          end
        end
        ST_ACQ_WR: begin
          if (!avm.avm_waitrequest) begin
            state_q    <= ST_ACQ_RD;
            avmWrite_q <= 1'b0;
            avmRead_q  <= 1'b1;
            avmWdata_q <= MUTEX_OWNER_FREE;
          end
        end
        ST_ACQ_RD: begin
          if (!avm.avm_waitrequest) begin
            avmRead_q <= 1'b0;
            if (acquireOk) begin
              state_q  <= ST_HELD;
              locked_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              state_q <= ST_BACKOFF;
              if (retries_q != '1) begin
                retries_q <= retries_q + RETRY_W'(1);
              end
            end
          end
        end
        ST_BACKOFF: begin
          if (backoffExpired) begin
            state_q    <= ST_ACQ_WR;
            avmWrite_q <= 1'b1;
            avmAddr_q  <= MUTEX_ADDR_ACQUIRE;
            avmWdata_q <= ACCEL_ID;
          end
        end
        ST_HELD: begin
          if (unlock_req) begin
            state_q    <= ST_REL_WR;
            avmWrite_q <= 1'b1;
            avmAddr_q  <= MUTEX_ADDR_RELEASE;
            avmWdata_q <= ACCEL_ID;
          end else if (lock_req) begin
            done_q <= 1'b1;
          end
        end
        ST_REL_WR: begin
          if (!avm.avm_waitrequest) begin
            state_q    <= ST_IDLE;
            avmWrite_q <= 1'b0;
            avmAddr_q  <= MUTEX_ADDR_ACQUIRE;
            avmWdata_q <= MUTEX_OWNER_FREE;
            locked_q   <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done              = done_q;
  assign locked            = locked_q;
  assign retries           = retries_q;
  assign avm.avm_read      = avmRead_q;
  assign avm.avm_write     = avmWrite_q;
  assign avm.avm_address   = avmAddr_q;
  assign avm.avm_writedata = avmWdata_q;

endmodule

// File: tb/tb_legup_mutex_client.sv
// tb_legup_mutex_client
// Self-checking bench for legup_mutex_client: a behavioural mutex slave with
// scripted wait states and owner values, a table of lock scenarios, corner
// sequences, asynchronous reset mid-transaction and a randomized request mix.
module tb_legup_mutex_client;
  import legup_mutex_pkg::*;

  localparam logic [31:0] ID = 32'h0000_0001;
  localparam int          BW = 3;
  localparam int          RW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lock_req = 1'b0;
  logic          unlock_req = 1'b0;
  logic          done;
  logic          locked;
  logic [RW-1:0] retries;

  legup_mutex_client_if bus ();

  legup_mutex_client #(
    .ACCEL_ID  (ID),
    .BACKOFF_W (BW),
    .RETRY_W   (RW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lock_req   (lock_req),
    .unlock_req (unlock_req),
    .done       (done),
    .locked     (locked),
    .retries    (retries),
    .avm        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Behavioural mutex slave: each transfer pops its wait-state count from
  // waitQ, each read pops the owner value from ownerQ. Accepted transfers
  // are logged with the clock edge that accepts them.
  typedef struct {
    bit          isWrite;
    logic        addr;
    logic [31:0] data;
    int          cycle;
  } txn_t;

  int          waitQ[$];
  logic [31:0] ownerQ[$];
  txn_t        logQ[$];
  bit          inTxn = 0;
  bit          lastWait = 0;
  int          waitLeft = 0;
  logic [34:0] lastBus;
  logic [34:0] nowBus;

  always @(negedge clk) begin
    if (!reset_n) begin
      inTxn = 0;
      lastWait = 0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata = '0;
    end else begin
      nowBus = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
      if (lastWait) checkOutput("strobes stable under waitrequest", nowBus, lastBus);
      if (bus.avm_read || bus.avm_write) begin
        checkOutput("read/write exclusive", 64'(bus.avm_read & bus.avm_write), 64'd0);
        if (!inTxn) begin
          inTxn = 1;
          waitLeft = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
        end
        if (waitLeft > 0) begin
          // Decoy owner value during a stall: sampling it early would grant.
          waitLeft--;
          bus.avm_waitrequest = 1'b1;
          bus.avm_readdata = ID;
          lastWait = 1;
        end else begin
          bus.avm_waitrequest = 1'b0;
          lastWait = 0;
          inTxn = 0;
          if (bus.avm_read) bus.avm_readdata = (ownerQ.size() > 0) ? ownerQ.pop_front() : ID;
          else bus.avm_readdata = $urandom();
          logQ.push_back('{bus.avm_write, bus.avm_address, bus.avm_writedata, cyc + 1});
        end
        lastBus = nowBus;
      end else begin
        bus.avm_waitrequest = 1'b0;
        lastWait = 0;
        bus.avm_readdata = $urandom();
      end
    end
  end

  function automatic int backoffLen(input int i);
    int maxLen = (1 << BW) - 1;
    if (i >= BW) return maxLen;
    return ((1 << i) < maxLen) ? (1 << i) : maxLen;
  endfunction

  task automatic applyStimulus(input bit lock, input bit unlock, output int k);
    @(negedge clk);
    lock_req = lock;
    unlock_req = unlock;
    k = cyc;
  endtask

  task automatic waitDone(input int budget, output int edgeNum, output bit busSeen);
    bit seen = 0;
    busSeen = 0;
    edgeNum = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.avm_read || bus.avm_write) busSeen = 1;
      if (done) begin
        seen = 1;
        edgeNum = cyc;
      end
    end
    if (!seen) checkOutput("done timeout", 64'd0, 64'd1);
  endtask

  // Drop both requests after done and confirm done lasts one cycle.
  task automatic finishRequest(input string tag);
    int k;
    applyStimulus(0, 0, k);
    @(posedge clk);
    #1;
    checkOutput({tag, " done one-cycle"}, 64'(done), 64'd0);
  endtask

  // One lock request. The first nFail read-backs return rival; waits are
  // per transfer. Expected edges follow from: write starts one edge after
  // the request is sampled, each transfer takes 1+waits edges, a failed
  // attempt is followed by backoffLen(i) idle cycles.
  task automatic runLock(input string tag, input int nFail, input logic [31:0] rival,
                         input int wwFix, input int rwFix, input bit randWaits,
                         input bit alsoUnlock, output int lat, output int ret);
    int attempts, t, k, gotEdge, logStart, wwA, rwA, expRet;
    int aw[];
    int ar[];
    bit busSeen;
    attempts = nFail + 1;
    aw = new[attempts];
    ar = new[attempts];
    logStart = logQ.size();
    t = 1;
    for (int i = 0; i < attempts; i++) begin
      wwA = randWaits ? int'($urandom_range(0, 3)) : wwFix;
      rwA = randWaits ? int'($urandom_range(0, 3)) : rwFix;
      waitQ.push_back(wwA);
      waitQ.push_back(rwA);
      ownerQ.push_back((i < nFail) ? rival : ID);
      aw[i] = t + 1 + wwA;
      ar[i] = aw[i] + 1 + rwA;
      if (i < nFail) t = ar[i] + backoffLen(i);
    end
    expRet = (nFail < (1 << RW) - 1) ? nFail : (1 << RW) - 1;
    applyStimulus(1, alsoUnlock, k);
    waitDone(ar[attempts-1] + 40, gotEdge, busSeen);
    lat = gotEdge - k;
    ret = int'(retries);
    checkOutput({tag, " lock latency"}, 64'(lat), 64'(ar[attempts-1]));
    checkOutput({tag, " locked"}, 64'(locked), 64'd1);
    checkOutput({tag, " retries"}, 64'(retries), 64'(expRet));
    finishRequest(tag);
    checkOutput({tag, " transfer count"}, 64'(logQ.size() - logStart), 64'(2 * attempts));
    if (logQ.size() - logStart == 2 * attempts) begin
      for (int i = 0; i < attempts; i++) begin
        txn_t w = logQ[logStart + 2*i];
        txn_t r = logQ[logStart + 2*i + 1];
        checkOutput({tag, " acquire write"}, {30'd0, w.isWrite, w.addr, w.data},
                    {30'd0, 1'b1, MUTEX_ADDR_ACQUIRE, ID});
        checkOutput({tag, " acquire write edge"}, 64'(w.cycle - k), 64'(aw[i]));
        checkOutput({tag, " owner read"}, {62'd0, r.isWrite, r.addr}, {62'd0, 1'b0, MUTEX_ADDR_ACQUIRE});
        checkOutput({tag, " owner read edge"}, 64'(r.cycle - k), 64'(ar[i]));
      end
    end
  endtask

  task automatic runRelease(input string tag, input int ww, input bit alsoLock);
    int k, gotEdge, logStart;
    bit busSeen;
    logStart = logQ.size();
    waitQ.push_back(ww);
    applyStimulus(alsoLock, 1, k);
    waitDone(ww + 20, gotEdge, busSeen);
    checkOutput({tag, " release latency"}, 64'(gotEdge - k), 64'(2 + ww));
    checkOutput({tag, " unlocked"}, 64'(locked), 64'd0);
    finishRequest(tag);
    checkOutput({tag, " release count"}, 64'(logQ.size() - logStart), 64'd1);
    if (logQ.size() - logStart == 1) begin
      checkOutput({tag, " release write"},
                  {30'd0, logQ[logStart].isWrite, logQ[logStart].addr, logQ[logStart].data},
                  {30'd0, 1'b1, MUTEX_ADDR_RELEASE, ID});
      checkOutput({tag, " release write edge"}, 64'(logQ[logStart].cycle - k), 64'(2 + ww));
    end
  endtask

  // Requests answered locally: done one cycle later and no bus transfer.
  task automatic runNoBus(input string tag, input bit lock, input bit unlock, input bit expLocked);
    int k, gotEdge, logStart;
    bit busSeen;
    logStart = logQ.size();
    applyStimulus(lock, unlock, k);
    waitDone(5, gotEdge, busSeen);
    checkOutput({tag, " done latency"}, 64'(gotEdge - k), 64'd1);
    checkOutput({tag, " no strobes"}, 64'(busSeen), 64'd0);
    checkOutput({tag, " locked"}, 64'(locked), 64'(expLocked));
    finishRequest(tag);
    checkOutput({tag, " no transfers"}, 64'(logQ.size() - logStart), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " done"}, 64'(done), 64'd0);
    checkOutput({tag, " locked"}, 64'(locked), 64'd0);
    checkOutput({tag, " retries"}, 64'(retries), 64'd0);
    checkOutput({tag, " avm_read"}, 64'(bus.avm_read), 64'd0);
    checkOutput({tag, " avm_write"}, 64'(bus.avm_write), 64'd0);
    checkOutput({tag, " avm_address"}, 64'(bus.avm_address), 64'd0);
    checkOutput({tag, " avm_writedata"}, 64'(bus.avm_writedata), 64'd0);
  endtask

  task automatic waitUntilEdge(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("reached reset point", 64'(cyc), 64'(target));
  endtask

  task automatic pulseReset(input string tag);
    reset_n = 1'b0;
    lock_req = 1'b0;
    unlock_req = 1'b0;
    #1;
    checkResetValues(tag);
    waitQ.delete();
    ownerQ.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int          nFail;
    int          ww;
    int          rw;
    logic [31:0] rival;
    int          expLat;
    int          expRetries;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, ret, k;
    bit mLocked;
    logic [31:0] rival;

    // Latencies: 1 + sum(2 + waits) over attempts + backoffs 1,2,4,7,7...
    vecs[0] = '{0, 0, 0, 32'h0000_0000, 3, 0};
    vecs[1] = '{3, 0, 0, 32'h0000_0005, 16, 3};
    vecs[2] = '{0, 4, 2, 32'h0000_0000, 9, 0};
    vecs[3] = '{1, 1, 1, 32'h0000_0000, 10, 1};
    vecs[4] = '{2, 2, 0, 32'hDEAD_BEEF, 16, 2};
    vecs[5] = '{5, 0, 0, 32'h0000_0002, 34, 5};
    vecs[6] = '{9, 0, 0, 32'h0000_0003, 70, 7};

    repeat (3) @(negedge clk);
    checkResetValues("power-on reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      runLock(tag, vecs[v].nFail, vecs[v].rival, vecs[v].ww, vecs[v].rw, 0, 0, lat, ret);
      checkOutput({tag, " table latency"}, 64'(lat), 64'(vecs[v].expLat));
      checkOutput({tag, " table retries"}, 64'(ret), 64'(vecs[v].expRetries));
      runRelease(tag, 0, 0);
    end

    $display("[TB] corner sequences");
    runNoBus("unlock in idle", 0, 1, 0);
    runLock("lock+unlock in idle", 0, 32'h0, 0, 0, 0, 1, lat, ret);
    runNoBus("lock in held", 1, 0, 1);
    runRelease("both in held", 3, 1);

    $display("[TB] reset during backoff");
    ownerQ.push_back(32'h0000_0009);
    ownerQ.push_back(32'h0000_0009);
    applyStimulus(1, 0, k);
    waitUntilEdge(k + 6);
    checkOutput("backoff retries before reset", 64'(retries), 64'd2);
    pulseReset("reset in backoff");
    runLock("after backoff reset", 0, 32'h0, 0, 0, 0, 0, lat, ret);
    runRelease("after backoff reset", 0, 0);

    $display("[TB] reset during stalled acquire write");
    waitQ.push_back(20);
    applyStimulus(1, 0, k);
    waitUntilEdge(k + 3);
    checkOutput("write stalled before reset", 64'(bus.avm_write), 64'd1);
    pulseReset("reset in acq_wr");
    runLock("after stall reset", 1, 32'h0000_0004, 1, 0, 0, 0, lat, ret);
    runRelease("after stall reset", 1, 0);

    $display("[TB] randomized requests");
    mLocked = 0;
    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 2);
      rival = ($urandom() & 32'hFFFF_FFF0) | 32'h2;
      if (!mLocked) begin
        if (op == 1) begin
          runNoBus("rand unlock idle", 0, 1, 0);
        end else begin
          runLock("rand lock", $urandom_range(0, 4), rival, 0, 0, 1, op == 2, lat, ret);
          mLocked = 1;
        end
      end else begin
        if (op == 0) begin
          runNoBus("rand relock", 1, 0, 1);
        end else begin
          runRelease("rand release", $urandom_range(0, 3), op == 2);
          mLocked = 0;
        end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/legup_mutex_client.md
# legup_mutex_client

Avalon-MM master-side client that lets one accelerator acquire and release a single hardware mutex slave. It converts a simple lock/unlock request handshake from the accelerator datapath into the mutex's bus protocol: acquire-write, owner read-back, exponential backoff and release-write. One instance sits beside each accelerator that shares a mutex-protected resource, connected to the system interconnect as a master.

## Interface
Parameters:
- ACCEL_ID, 32'h0000_0001: this client's owner ID; must be nonzero, because an owner value of 0 means "free".
- BACKOFF_W, 8: width of the backoff counter. Maximum backoff is 2^BACKOFF_W-1 cycles.
- RETRY_W, 16: width of the retry counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- lock_req  in  1  request to acquire; level, sampled in IDLE or HELD.
- unlock_req  in  1  request to release; level, sampled in HELD or IDLE.
- done  out  1  one-cycle pulse when a lock or unlock request completes.
- locked  out  1  high while this client owns the mutex.
- retries  out  RETRY_W  failed acquire attempts in the current lock request; saturating.
- avm_address  out  1  0 = acquire/owner word, 1 = release word.
- avm_read  out  1  Avalon read strobe.
- avm_write  out  1  Avalon write strobe.
- avm_writedata  out  32  always ACCEL_ID when a write is issued.
- avm_readdata  in  32  owner ID; read latency 0, valid in the accept cycle.
- avm_waitrequest  in  1  stalls the current read or write.

## Operation
States: IDLE, ACQ_WR, ACQ_RD, BACKOFF, HELD, REL_WR.

- **IDLE**
  - lock_req=1: go to ACQ_WR, clear retries, set backoff length to 1.
  - unlock_req=1 with lock_req=0: pulse done, issue no bus cycle, stay in IDLE.
  - lock_req and unlock_req both high: lock wins.
- **ACQ_WR**: drive avm_write=1, avm_address=0, avm_writedata=ACCEL_ID. When avm_waitrequest=0, go to ACQ_RD.
- **ACQ_RD**: drive avm_read=1, avm_address=0. When avm_waitrequest=0, sample avm_readdata:
  - readdata == ACCEL_ID: go to HELD, set locked=1, pulse done.
  - otherwise: increment retries (saturating), load the backoff counter with the current length, go to BACKOFF.
- **BACKOFF**: count down with no bus activity. At 0, double the backoff length, saturating at all-ones, and go to ACQ_WR.
- **HELD**
  - unlock_req=1: go to REL_WR.
  - lock_req=1 with unlock_req=0: pulse done, stay in HELD (re-entrant acquire, no bus cycle).
  - Both high: unlock wins.
- **REL_WR**: drive avm_write=1, avm_address=1, avm_writedata=ACCEL_ID. When avm_waitrequest=0, go to IDLE, set locked=0, pulse done.

General rules:
- Requests are not cancellable. lock_req deasserting during ACQ_WR, ACQ_RD or BACKOFF does not abort the sequence.
- avm_read and avm_write are never both high.
- Bus strobes hold steady, with stable address and data, while avm_waitrequest=1.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE
  - done=0, locked=0, retries=0
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0
  - backoff length=1
- Best-case lock (no wait states), with lock_req sampled high at edge 0:
  - edge 1: avm_write=1.
  - edge 2: avm_read=1.
  - edge 3: locked=1 and done=1.
  - Latency is 3 cycles.
- Each waitrequest cycle adds 1 cycle.
- A failed attempt costs 2 bus cycles plus the backoff length. Successive backoffs are 1, 2, 4, … cycles, up to 2^BACKOFF_W-1.
- Unlock from HELD: avm_write=1 at edge 1; done=1 and locked=0 at edge 2.
- done from IDLE-unlock or HELD-lock appears 1 cycle after the sampling edge.
- done is high for exactly one cycle per completed request. The client requires both requests to be low in the cycle after done before it starts a new request.
- Asynchronous reset mid-transaction drops the strobes immediately and returns to IDLE. A mutex already granted stays held in the slave; system-level reset of the slave is responsible for clearing it.

## Structure
- Shared package legup_mutex_pkg:
  - MUTEX_ADDR_ACQUIRE=1'b0, MUTEX_ADDR_RELEASE=1'b1.
  - MUTEX_OWNER_FREE=32'h0.
  - The state enum mutex_client_state_t.
  - The slave uses the same address constants.
- Sub-module legup_mutex_backoff holds the exponential backoff length register and the down-counter. It has load, tick and expired signals and is parameterized by BACKOFF_W.
- The top level holds the FSM and the Avalon output registers.

## Test plan
- Free mutex, no waitrequest: lock_req=1 at cycle 0 → write addr 0 data 0x1 at cycle 1, read at cycle 2 with readdata 0x1 → locked=1 and done=1 at cycle 3, retries=0.
- Contended: the model returns readdata=0x5 three times, then 0x1 → retries=3, backoff gaps of 1, 2 and 4 idle bus cycles between attempts, then locked=1.
- Waitrequest stress: hold waitrequest=1 for 4 cycles on the acquire write and 2 on the read → strobes, address and data stay stable throughout, locked asserts at cycle 9.
- Release: in HELD, assert unlock_req=1 → write addr 1 data 0x1 one cycle later, then done=1 and locked=0.
- Corner cases:
  - lock_req in HELD → done 1 cycle later, no bus cycle.
  - unlock_req in IDLE → done, no bus cycle.
  - Both requests in HELD → release.
- reset_n=0 during BACKOFF and during a stalled ACQ_WR → all outputs at reset values immediately. After reset_n=1, a fresh lock completes normally.
